// File: rtl/klotski_pkg.sv
// Shared Klotski definitions, used by the move sequencer and by the solver
// and display blocks.
//   BOARD_COLS / BOARD_ROWS : board size in cells
//   dir_t                   : push direction encoding as it appears on the command bus
//   seq_state_t             : move sequencer state encoding
package klotski_pkg;

  localparam logic [2:0] BOARD_COLS = 3'd4;
  localparam logic [2:0] BOARD_ROWS = 3'd5;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,  // row - 1
    DIR_DOWN  = 2'd1,  // row + 1
    DIR_LEFT  = 2'd2,  // col - 1
    DIR_RIGHT = 2'd3   // col + 1
  } dir_t;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_CHECK     = 4'd1,
    S_GOTO_X    = 4'd2,
    S_WAIT_X    = 4'd3,
    S_GOTO_Y    = 4'd4,
    S_WAIT_Y    = 4'd5,
    S_GRAB      = 4'd6,
    S_PUSH      = 4'd7,
    S_WAIT_PUSH = 4'd8,
    S_RELEASE   = 4'd9,
    S_DONE      = 4'd10
  } seq_state_t;

endpackage

// File: rtl/klotski_axis_cmd.sv
// Converts a cell move on one axis (current position -> target) into a
// motor channel command.
//   pos_i    : current gantry cell on this axis
//   target_i : cell to travel to
//   dir_o    : 1 = increasing index, 0 = decreasing
//   steps_o  : |target - pos| * STEPS_PER_CELL
//   skip_o   : target equals position, so no command must be issued
module klotski_axis_cmd
  import klotski_pkg::*;
#(
  parameter int unsigned STEPS_PER_CELL = 400
) (
  input  logic [2:0]  pos_i,
  input  logic [2:0]  target_i,
  output logic        dir_o,
  output logic [31:0] steps_o,
  output logic        skip_o
);

  logic signed [3:0] delta;
  logic        [2:0] mag;

  always_comb begin
    delta   = $signed({1'b0, target_i}) - $signed({1'b0, pos_i});
    mag     = delta[3] ? 3'(-delta) : delta[2:0];
    dir_o   = ~delta[3];
    skip_o  = (delta == 4'sd0);
    steps_o = 32'(mag) * STEPS_PER_CELL;
  end

endmodule

// File: rtl/klotski_move_sequencer.sv
// Klotski move sequencer: accepts one piece move per valid/ready handshake,
// tracks the gantry cell position and drives the X/Y stepper channels through
// travel-to-source (X then Y), magnet on, push, magnet off.
//
// Handshake: a command is taken on any rising clock edge where
// i_cmd_valid && o_cmd_ready; o_cmd_ready is high only while idle, and the
// command fields must be stable whenever i_cmd_valid is high.
//
// Ports:
//   i_Clk, i_rst                     clock, synchronous active-high reset
//   i_cmd_valid/o_cmd_ready          command handshake
//   i_cmd_col/row/dir/cells          source cell, push direction, push distance
//   o_x_en/o_y_en                    one-cycle channel start pulses
//   o_x_dir/o_y_dir, o_x/y_steps     channel command, held from pulse until done
//   i_x_done/i_y_done                one-cycle channel completion pulses
//   o_magnet                         electromagnet drive
//   o_busy                           high whenever not idle
//   o_move_done / o_cmd_err          one-cycle completion / rejection pulses
//   o_dbg_state, o_dbg_pos_col/row   FSM state and gantry cell for observation
//
// Build option: define MAGNET_SETTLE_EN to hold S_GRAB and S_RELEASE for
// SETTLE_CYCLES clocks each (magnet changes on entry). Without it each is one
// cycle and the dwell counter does not exist.
module klotski_move_sequencer
  import klotski_pkg::*;
#(
  parameter int unsigned STEPS_PER_CELL = 400,
  parameter int unsigned SETTLE_CYCLES  = 500000
) (
  input  logic        i_Clk,
  input  logic        i_rst,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic [2:0]  i_cmd_col,
  input  logic [2:0]  i_cmd_row,
  input  logic [1:0]  i_cmd_dir,
  input  logic [1:0]  i_cmd_cells,
  output logic        o_x_en,
  output logic        o_y_en,
  output logic        o_x_dir,
  output logic        o_y_dir,
  output logic [31:0] o_x_steps,
  output logic [31:0] o_y_steps,
  input  logic        i_x_done,
  input  logic        i_y_done,
  output logic        o_magnet,
  output logic        o_busy,
  output logic        o_move_done,
  output logic        o_cmd_err,
  output logic [3:0]  o_dbg_state,
  output logic [2:0]  o_dbg_pos_col,
  output logic [2:0]  o_dbg_pos_row
);

  seq_state_t  state_q, state_d;
  logic [2:0]  cmd_col_q, cmd_col_d;
  logic [2:0]  cmd_row_q, cmd_row_d;
  dir_t        cmd_dir_q, cmd_dir_d;
  logic [1:0]  cmd_cells_q, cmd_cells_d;
  logic [2:0]  pos_col_q, pos_col_d;
  logic [2:0]  pos_row_q, pos_row_d;
  logic        x_en_q, x_en_d, y_en_q, y_en_d;
  logic        x_dir_q, x_dir_d, y_dir_q, y_dir_d;
  logic [31:0] x_steps_q, x_steps_d, y_steps_q, y_steps_d;
  logic        magnet_q, magnet_d;
  logic        move_done_q, move_done_d;
  logic        cmd_err_q, cmd_err_d;

  // Travel commands from the current position to the source cell.
  logic        x_cmd_dir, y_cmd_dir, x_skip, y_skip;
  logic [31:0] x_cmd_steps, y_cmd_steps;

  klotski_axis_cmd #(.STEPS_PER_CELL(STEPS_PER_CELL)) u_axis_x (
    .pos_i    (pos_col_q),
    .target_i (cmd_col_q),
    .dir_o    (x_cmd_dir),
    .steps_o  (x_cmd_steps),
    .skip_o   (x_skip)
  );

  klotski_axis_cmd #(.STEPS_PER_CELL(STEPS_PER_CELL)) u_axis_y (
    .pos_i    (pos_row_q),
    .target_i (cmd_row_q),
    .dir_o    (y_cmd_dir),
    .steps_o  (y_cmd_steps),
    .skip_o   (y_skip)
  );

  // Destination cell in signed 4-bit space so a push off the low edge shows
  // up as a negative value rather than wrapping to a large column/row.
  logic signed [3:0] dest_col_s, dest_row_s;
  logic              cmd_ok, push_vert, push_dir;
  logic [31:0]       push_steps;

  always_comb begin
    dest_col_s = $signed({1'b0, cmd_col_q});
    dest_row_s = $signed({1'b0, cmd_row_q});
    case (cmd_dir_q)
      DIR_UP:    dest_row_s = $signed({1'b0, cmd_row_q}) - $signed({2'b00, cmd_cells_q});
      DIR_DOWN:  dest_row_s = $signed({1'b0, cmd_row_q}) + $signed({2'b00, cmd_cells_q});
      DIR_LEFT:  dest_col_s = $signed({1'b0, cmd_col_q}) - $signed({2'b00, cmd_cells_q});
      default:   dest_col_s = $signed({1'b0, cmd_col_q}) + $signed({2'b00, cmd_cells_q});
    endcase
    cmd_ok = (cmd_col_q < BOARD_COLS) && (cmd_row_q < BOARD_ROWS) &&
             (cmd_cells_q != 2'd0) &&
             !dest_col_s[3] && (dest_col_s[2:0] < BOARD_COLS) &&
             !dest_row_s[3] && (dest_row_s[2:0] < BOARD_ROWS);
    push_vert  = (cmd_dir_q == DIR_UP) || (cmd_dir_q == DIR_DOWN);
    push_dir   = (cmd_dir_q == DIR_DOWN) || (cmd_dir_q == DIR_RIGHT);
    push_steps = 32'(cmd_cells_q) * STEPS_PER_CELL;
  end

  // Magnet dwell: settle_done is the "may leave S_GRAB/S_RELEASE" condition.
  logic settle_done;
`ifdef MAGNET_SETTLE_EN
  logic [31:0] dwell_q, dwell_d;

  always_comb begin
    settle_done = (dwell_q == SETTLE_CYCLES - 32'd1);
    dwell_d     = '0;
    if (((state_q == S_GRAB) || (state_q == S_RELEASE)) && !settle_done)
      dwell_d = dwell_q + 32'd1;
  end

  always_ff @(posedge i_Clk) begin
    if (i_rst) dwell_q <= '0;
    else       dwell_q <= dwell_d;
  end
`else
  assign settle_done = 1'b1;
`endif

  always_comb begin
    state_d     = state_q;
    cmd_col_d   = cmd_col_q;
    cmd_row_d   = cmd_row_q;
    cmd_dir_d   = cmd_dir_q;
    cmd_cells_d = cmd_cells_q;
    pos_col_d   = pos_col_q;
    pos_row_d   = pos_row_q;
    x_en_d      = 1'b0;
    y_en_d      = 1'b0;
    x_dir_d     = x_dir_q;
    y_dir_d     = y_dir_q;
    x_steps_d   = x_steps_q;
    y_steps_d   = y_steps_q;
    magnet_d    = magnet_q;
    move_done_d = 1'b0;
    cmd_err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_cmd_valid) begin
          cmd_col_d   = i_cmd_col;
          cmd_row_d   = i_cmd_row;
          cmd_dir_d   = dir_t'(i_cmd_dir);
          cmd_cells_d = i_cmd_cells;
          state_d     = S_CHECK;
        end
      end
      S_CHECK: begin
        if (cmd_ok) begin
          state_d = S_GOTO_X;
        end else begin
          cmd_err_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      // A zero-step start would still move one step, so equal cells skip.
      S_GOTO_X: begin
        if (x_skip) begin
          state_d = S_GOTO_Y;
        end else begin
          x_en_d    = 1'b1;
          x_dir_d   = x_cmd_dir;
          x_steps_d = x_cmd_steps;
          state_d   = S_WAIT_X;
        end
      end
      S_WAIT_X: begin
        if (i_x_done) begin
          pos_col_d = cmd_col_q;
          state_d   = S_GOTO_Y;
        end
      end
      S_GOTO_Y: begin
        if (y_skip) begin
          state_d = S_GRAB;
        end else begin
          y_en_d    = 1'b1;
          y_dir_d   = y_cmd_dir;
          y_steps_d = y_cmd_steps;
          state_d   = S_WAIT_Y;
        end
      end
      S_WAIT_Y: begin
        if (i_y_done) begin
          pos_row_d = cmd_row_q;
          state_d   = S_GRAB;
        end
      end
      S_GRAB: begin
        magnet_d = 1'b1;
        if (settle_done) state_d = S_PUSH;
      end
      S_PUSH: begin
        if (push_vert) begin
          y_en_d    = 1'b1;
          y_dir_d   = push_dir;
          y_steps_d = push_steps;
        end else begin
          x_en_d    = 1'b1;
          x_dir_d   = push_dir;
          x_steps_d = push_steps;
        end
        state_d = S_WAIT_PUSH;
      end
      // Only the channel that was started can end the push.
      S_WAIT_PUSH: begin
        if (push_vert ? i_y_done : i_x_done) begin
          pos_col_d = dest_col_s[2:0];
          pos_row_d = dest_row_s[2:0];
          state_d   = S_RELEASE;
        end
      end
      S_RELEASE: begin
        magnet_d = 1'b0;
        if (settle_done) state_d = S_DONE;
      end
      S_DONE: begin
        move_done_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      cmd_col_q   <= '0;
      cmd_row_q   <= '0;
      cmd_dir_q   <= DIR_UP;
      cmd_cells_q <= '0;
      pos_col_q   <= '0;
      pos_row_q   <= '0;
      x_en_q      <= 1'b0;
      y_en_q      <= 1'b0;
      x_dir_q     <= 1'b0;
      y_dir_q     <= 1'b0;
      x_steps_q   <= '0;
      y_steps_q   <= '0;
      magnet_q    <= 1'b0;
      move_done_q <= 1'b0;
      cmd_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_col_q   <= cmd_col_d;
      cmd_row_q   <= cmd_row_d;
      cmd_dir_q   <= cmd_dir_d;
      cmd_cells_q <= cmd_cells_d;
      pos_col_q   <= pos_col_d;
      pos_row_q   <= pos_row_d;
      x_en_q      <= x_en_d;
      y_en_q      <= y_en_d;
      x_dir_q     <= x_dir_d;
      y_dir_q     <= y_dir_d;
      x_steps_q   <= x_steps_d;
      y_steps_q   <= y_steps_d;
      magnet_q    <= magnet_d;
      move_done_q <= move_done_d;
      cmd_err_q   <= cmd_err_d;
    end
  end

  assign o_cmd_ready   = (state_q == S_IDLE);
  assign o_busy        = (state_q != S_IDLE);
  assign o_x_en        = x_en_q;
  assign o_y_en        = y_en_q;
  assign o_x_dir       = x_dir_q;
  assign o_y_dir       = y_dir_q;
  assign o_x_steps     = x_steps_q;
  assign o_y_steps     = y_steps_q;
  assign o_magnet      = magnet_q;
  assign o_move_done   = move_done_q;
  assign o_cmd_err     = cmd_err_q;
  assign o_dbg_state   = state_q;
  assign o_dbg_pos_col = pos_col_q;
  assign o_dbg_pos_row = pos_row_q;

endmodule

// File: tb/tb_klotski_move_sequencer.sv
// Bench for klotski_move_sequencer. A monitor logs every channel start as
// {magnet, axis(0=X,1=Y), dir, steps} and, when enabled, answers it with a
// done pulse after a random latency. A cell-level model of the gantry
// predicts the start list, the end position and err/done pulses per move.
module tb_klotski_move_sequencer;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_cmd_valid = 1'b0;
  logic [2:0]  i_cmd_col = '0;
  logic [2:0]  i_cmd_row = '0;
  logic [1:0]  i_cmd_dir = '0;
  logic [1:0]  i_cmd_cells = '0;
  logic        o_cmd_ready, o_x_en, o_y_en, o_x_dir, o_y_dir;
  logic [31:0] o_x_steps, o_y_steps;
  logic        o_magnet, o_busy, o_move_done, o_cmd_err;
  logic [3:0]  o_dbg_state;
  logic [2:0]  o_dbg_pos_col, o_dbg_pos_row;
  logic        i_x_done, i_y_done;
  logic        resp_x_done = 1'b0, resp_y_done = 1'b0;
  logic        man_x_done = 1'b0, man_y_done = 1'b0;

  assign i_x_done = resp_x_done | man_x_done;
  assign i_y_done = resp_y_done | man_y_done;

  klotski_move_sequencer #(.STEPS_PER_CELL(400), .SETTLE_CYCLES(10)) dut (
    .i_Clk(clk), .i_rst(i_rst), .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_col(i_cmd_col), .i_cmd_row(i_cmd_row), .i_cmd_dir(i_cmd_dir),
    .i_cmd_cells(i_cmd_cells), .o_x_en(o_x_en), .o_y_en(o_y_en),
    .o_x_dir(o_x_dir), .o_y_dir(o_y_dir), .o_x_steps(o_x_steps), .o_y_steps(o_y_steps),
    .i_x_done(i_x_done), .i_y_done(i_y_done), .o_magnet(o_magnet), .o_busy(o_busy),
    .o_move_done(o_move_done), .o_cmd_err(o_cmd_err), .o_dbg_state(o_dbg_state),
    .o_dbg_pos_col(o_dbg_pos_col), .o_dbg_pos_row(o_dbg_pos_row)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

`ifdef MAGNET_SETTLE_EN
  localparam int EXP_SETTLE = 10;
`else
  localparam int EXP_SETTLE = 1;
`endif

  int total = 0;
  int bad = 0;
  logic [34:0] exp_q[$];
  logic [34:0] obs_q[$];
  int   m_col = 0, m_row = 0;
  bit   resp_en = 1'b1;
  int   cyc = 0, t_mag = 0, t_push = 0;
  int   done_cnt = 0, err_cnt = 0;
  int   x_cnt = 0, y_cnt = 0;
  logic prev_mag = 1'b0;

  // ---------------- monitor / channel responder ----------------
  initial begin
    forever begin
      @(posedge clk); #1;
      cyc++;
      resp_x_done = 1'b0;
      resp_y_done = 1'b0;
      if (x_cnt > 0) begin x_cnt--; if (x_cnt == 0) resp_x_done = 1'b1; end
      if (y_cnt > 0) begin y_cnt--; if (y_cnt == 0) resp_y_done = 1'b1; end
      if (o_x_en) begin
        obs_q.push_back({o_magnet, 1'b0, o_x_dir, o_x_steps});
        if (resp_en) x_cnt = $urandom_range(1, 4);
        if (o_magnet) t_push = cyc;
      end
      if (o_y_en) begin
        obs_q.push_back({o_magnet, 1'b1, o_y_dir, o_y_steps});
        if (resp_en) y_cnt = $urandom_range(1, 4);
        if (o_magnet) t_push = cyc;
      end
      if (o_magnet && !prev_mag) t_mag = cyc;
      prev_mag = o_magnet;
      if (o_move_done) done_cnt++;
      if (o_cmd_err) err_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_cmd(input int col, input int row, input int dir, input int cells);
    int n;
    n = 0;
    while (!o_cmd_ready && n < 100) begin @(posedge clk); #1; n++; end
    total++;
    if (!o_cmd_ready) begin
      bad++;
      $display("FAIL ready_wait: got ready=%0b want 1", o_cmd_ready);
    end
    i_cmd_valid = 1'b1;
    i_cmd_col   = 3'(col);
    i_cmd_row   = 3'(row);
    i_cmd_dir   = 2'(dir);
    i_cmd_cells = 2'(cells);
    @(posedge clk); #1;
    i_cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (o_busy && n < 400) begin @(posedge clk); #1; n++; end
    total++;
    if (o_busy) begin
      bad++;
      $display("FAIL %s idle_timeout: got busy=%0b want 0", name, o_busy);
    end
    @(posedge clk); #1;
  endtask

  // Whole-move check against the cell model.
  task automatic run_move(input int col, input int row, input int dir, input int cells,
                          input string name);
    int dc, dr, ad, d0, e0;
    bit legal;
    logic [31:0] s;
    dc = col; dr = row;
    case (dir)
      0: dr = row - cells;
      1: dr = row + cells;
      2: dc = col - cells;
      default: dc = col + cells;
    endcase
    legal = (col < 4) && (row < 5) && (cells != 0) &&
            (dc >= 0) && (dc < 4) && (dr >= 0) && (dr < 5);
    exp_q.delete();
    if (legal) begin
      if (col != m_col) begin
        ad = (col > m_col) ? col - m_col : m_col - col;
        s = 32'(ad * 400);
        exp_q.push_back({1'b0, 1'b0, (col > m_col) ? 1'b1 : 1'b0, s});
      end
      if (row != m_row) begin
        ad = (row > m_row) ? row - m_row : m_row - row;
        s = 32'(ad * 400);
        exp_q.push_back({1'b0, 1'b1, (row > m_row) ? 1'b1 : 1'b0, s});
      end
      s = 32'(cells * 400);
      exp_q.push_back({1'b1, (dir < 2) ? 1'b1 : 1'b0, (dir == 1 || dir == 3) ? 1'b1 : 1'b0, s});
      m_col = dc;
      m_row = dr;
    end
    obs_q.delete();
    d0 = done_cnt;
    e0 = err_cnt;
    send_cmd(col, row, dir, cells);
    wait_idle(name);

    total++;
    if ((err_cnt - e0) !== (legal ? 0 : 1)) begin
      bad++;
      $display("FAIL %s err_pulses: got %0d want %0d", name, err_cnt - e0, legal ? 0 : 1);
    end
    total++;
    if ((done_cnt - d0) !== (legal ? 1 : 0)) begin
      bad++;
      $display("FAIL %s done_pulses: got %0d want %0d", name, done_cnt - d0, legal ? 1 : 0);
    end
    total++;
    if (obs_q.size() !== exp_q.size()) begin
      bad++;
      $display("FAIL %s start_count: got %0d want %0d", name, obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL %s start[%0d] {mag,axis,dir,steps}: got %h want %h",
                 name, i, obs_q[i], exp_q[i]);
      end
    end
    total++;
    if (o_dbg_pos_col !== 3'(m_col) || o_dbg_pos_row !== 3'(m_row)) begin
      bad++;
      $display("FAIL %s pos: got (%0d,%0d) want (%0d,%0d)",
               name, o_dbg_pos_col, o_dbg_pos_row, m_col, m_row);
    end
    total++;
    if (o_magnet !== 1'b0) begin
      bad++;
      $display("FAIL %s magnet_after: got %0b want 0", name, o_magnet);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    i_rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    i_rst = 1'b0;
    m_col = 0; m_row = 0;
    total++;
    if ({o_cmd_ready, o_busy, o_x_en, o_y_en, o_x_dir, o_y_dir, o_magnet, o_move_done, o_cmd_err}
        !== 9'b1_0000_0000) begin
      bad++;
      $display("FAIL reset_ctrl: got rdy=%0b busy=%0b xen=%0b yen=%0b xd=%0b yd=%0b mag=%0b done=%0b err=%0b want rdy=1 others 0",
               o_cmd_ready, o_busy, o_x_en, o_y_en, o_x_dir, o_y_dir, o_magnet, o_move_done, o_cmd_err);
    end
    total++;
    if (o_x_steps !== 32'd0 || o_y_steps !== 32'd0) begin
      bad++;
      $display("FAIL reset_steps: got %0d/%0d want 0/0", o_x_steps, o_y_steps);
    end
    total++;
    if (o_dbg_pos_col !== 3'd0 || o_dbg_pos_row !== 3'd0) begin
      bad++;
      $display("FAIL reset_pos: got (%0d,%0d) want (0,0)", o_dbg_pos_col, o_dbg_pos_row);
    end
  endtask

  task automatic test_travel_push();
    run_move(1, 3, 3, 1, "travel_push");
    total++;
    if (o_dbg_pos_col !== 3'd2 || o_dbg_pos_row !== 3'd3) begin
      bad++;
      $display("FAIL travel_push_final: got (%0d,%0d) want (2,3)", o_dbg_pos_col, o_dbg_pos_row);
    end
  endtask

  task automatic test_no_travel();
    run_move(2, 3, 0, 2, "no_travel");
    total++;
    if (o_dbg_pos_col !== 3'd2 || o_dbg_pos_row !== 3'd1) begin
      bad++;
      $display("FAIL no_travel_final: got (%0d,%0d) want (2,1)", o_dbg_pos_col, o_dbg_pos_row);
    end
  endtask

  task automatic test_reject();
    // Timing: err one cycle after accept, ready high in that same cycle.
    obs_q.delete();
    send_cmd(3, 0, 3, 1);
    @(posedge clk); #1;
    total++;
    if (o_cmd_err !== 1'b1 || o_cmd_ready !== 1'b1 || o_magnet !== 1'b0) begin
      bad++;
      $display("FAIL reject_timing: got err=%0b rdy=%0b mag=%0b want 1 1 0",
               o_cmd_err, o_cmd_ready, o_magnet);
    end
    @(posedge clk); #1;
    total++;
    if (o_cmd_err !== 1'b0 || obs_q.size() !== 0) begin
      bad++;
      $display("FAIL reject_after: got err=%0b starts=%0d want 0 0", o_cmd_err, obs_q.size());
    end
    run_move(3, 0, 3, 1, "reject_off_right");
    run_move(1, 1, 1, 0, "reject_cells0");
    run_move(4, 0, 1, 1, "reject_col4");
    run_move(0, 5, 0, 1, "reject_row5");
    run_move(0, 0, 0, 1, "reject_off_top");
  endtask

  task automatic test_spurious_and_reset();
    int n, col;
    bit push_seen;
    resp_en = 1'b0;
    col = (m_col == 0) ? 1 : 0;
    obs_q.delete();
    send_cmd(col, 2, 1, 1);
    n = 0;
    while (obs_q.size() == 0 && n < 20) begin @(posedge clk); #1; n++; end
    total++;
    if (obs_q.size() !== 1) begin
      bad++;
      $display("FAIL spur_x_start: got %0d starts want 1", obs_q.size());
    end
    man_y_done = 1'b1;
    @(posedge clk); #1;
    man_y_done = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (obs_q.size() !== 1 || o_busy !== 1'b1 || o_dbg_pos_col !== 3'(m_col)) begin
      bad++;
      $display("FAIL spur_y_ignored: got starts=%0d busy=%0b col=%0d want 1 1 %0d",
               obs_q.size(), o_busy, o_dbg_pos_col, m_col);
    end
    man_x_done = 1'b1;
    push_seen = 1'b0;
    n = 0;
    while (!push_seen && n < 40) begin
      @(posedge clk); #1;
      man_x_done = 1'b0;
      man_y_done = 1'b0;
      if ((o_x_en || o_y_en) && o_magnet) push_seen = 1'b1;
      else if (o_y_en) man_y_done = 1'b1;
      n++;
    end
    total++;
    if (!push_seen) begin
      bad++;
      $display("FAIL spur_push_start: got none want push start");
    end
    // Now waiting for the push; reset mid-move.
    @(posedge clk); #1;
    i_rst = 1'b1;
    @(posedge clk); #1;
    i_rst = 1'b0;
    total++;
    if (o_magnet !== 1'b0 || o_busy !== 1'b0 || o_cmd_ready !== 1'b1 ||
        o_dbg_pos_col !== 3'd0 || o_dbg_pos_row !== 3'd0) begin
      bad++;
      $display("FAIL mid_reset: got mag=%0b busy=%0b rdy=%0b pos=(%0d,%0d) want 0 0 1 (0,0)",
               o_magnet, o_busy, o_cmd_ready, o_dbg_pos_col, o_dbg_pos_row);
    end
    m_col = 0; m_row = 0;
    resp_en = 1'b1;
  endtask

  task automatic test_settle();
    run_move(0, 0, 1, 2, "settle_move");
    total++;
    if ((t_push - t_mag) !== EXP_SETTLE) begin
      bad++;
      $display("FAIL settle_cycles: got %0d want %0d", t_push - t_mag, EXP_SETTLE);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 25; k++) begin
      run_move($urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 3),
               $urandom_range(0, 2), "random");
    end
  endtask

  task automatic test_back_to_back();
    run_move(0, 2, 3, 2, "b2b_a");
    run_move(2, 2, 2, 2, "b2b_b");
    run_move(0, 2, 0, 2, "b2b_c");
  endtask

  initial begin
    test_reset();
    test_travel_push();
    test_no_travel();
    test_reject();
    test_spurious_and_reset();
    test_settle();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
